// File: rtl/toggle_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : toggle_stream_decoder
// Brief    : Decodes a toggle-encoded serial line, hunts for a sync word,
//            assembles a data byte plus even-parity bit, and hands the byte
//            off through a valid/ready holding register.
// Revision : 1.0 - initial release
// ============================================================================
module toggle_stream_decoder #(
    parameter logic [7:0] SYNC_WORD = 8'h7E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic       line_in,
    input  logic       data_ready,
    input  logic       overrun_clr,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       overrun,
    output logic [7:0] frame_cnt
);

    localparam logic [1:0] S_HUNT   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;

    logic [1:0] r_state;
    logic       r_prev_line;
    logic [7:0] r_hunt_sr;
    logic [7:0] r_data_sr;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_data_out;
    logic       r_data_valid;
    logic       r_parity_err;
    logic       r_overrun;
    logic [7:0] r_frame_cnt;

    logic [1:0] w_state_nxt;
    logic       w_prev_line_nxt;
    logic [7:0] w_hunt_sr_nxt;
    logic [7:0] w_data_sr_nxt;
    logic [2:0] w_bit_cnt_nxt;
    logic [7:0] w_data_out_nxt;
    logic       w_data_valid_nxt;
    logic       w_parity_err_nxt;
    logic       w_overrun_nxt;
    logic [7:0] w_frame_cnt_nxt;
    logic       w_d;
    logic       w_complete;
    logic       w_parity_bad;

    assign w_d          = line_in ^ r_prev_line;
    assign w_parity_bad = (^r_data_sr) ^ w_d;

    always_comb begin
        w_state_nxt      = r_state;
        w_prev_line_nxt  = r_prev_line;
        w_hunt_sr_nxt    = r_hunt_sr;
        w_data_sr_nxt    = r_data_sr;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_data_out_nxt   = r_data_out;
        w_data_valid_nxt = r_data_valid;
        w_parity_err_nxt = r_parity_err;
        w_overrun_nxt    = r_overrun;
        w_frame_cnt_nxt  = r_frame_cnt;
        w_complete       = 1'b0;

        if (sample_en) begin
            w_prev_line_nxt = line_in;
            case (r_state)
                S_HUNT: begin
                    w_hunt_sr_nxt = {r_hunt_sr[6:0], w_d};
                    if (w_hunt_sr_nxt == SYNC_WORD) begin
                        w_state_nxt   = S_DATA;
                        w_bit_cnt_nxt = 3'd0;
                    end
                end
                S_DATA: begin
                    w_data_sr_nxt[r_bit_cnt] = w_d;
                    w_bit_cnt_nxt            = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_complete    = 1'b1;
                    w_state_nxt   = S_HUNT;
                    w_hunt_sr_nxt = 8'h00;
                end
                default: w_state_nxt = S_HUNT;
            endcase
        end

        // A consume and a fresh load in the same cycle keep data_valid high.
        if (w_complete) begin
            w_frame_cnt_nxt = r_frame_cnt + 8'd1;
            if (!r_data_valid || data_ready) begin
                w_data_out_nxt   = r_data_sr;
                w_parity_err_nxt = w_parity_bad;
                w_data_valid_nxt = 1'b1;
            end else begin
                w_overrun_nxt = 1'b1;
            end
        end else if (r_data_valid && data_ready) begin
            w_data_valid_nxt = 1'b0;
        end

        if (overrun_clr && !(w_complete && r_data_valid && !data_ready)) begin
            w_overrun_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_HUNT;
            r_prev_line  <= 1'b0;
            r_hunt_sr    <= 8'h00;
            r_data_sr    <= 8'h00;
            r_bit_cnt    <= 3'd0;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_cnt  <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_line  <= w_prev_line_nxt;
            r_hunt_sr    <= w_hunt_sr_nxt;
            r_data_sr    <= w_data_sr_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_data_out   <= w_data_out_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_parity_err <= w_parity_err_nxt;
            r_overrun    <= w_overrun_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_toggle_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_toggle_stream_decoder
// Brief    : Directed, table-driven self-checking bench for
//            toggle_stream_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_stream_decoder;

    logic       clk;
    logic       rst;
    logic       sample_en;
    logic       line_in;
    logic       data_ready;
    logic       overrun_clr;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       overrun;
    logic [7:0] frame_cnt;

    int n_checks;
    int n_fail;

    toggle_stream_decoder #(.SYNC_WORD(8'h7E)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .line_in     (line_in),
        .data_ready  (data_ready),
        .overrun_clr (overrun_clr),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .parity_err  (parity_err),
        .overrun     (overrun),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       rdy;
        logic [7:0] exp_out;
        logic       exp_valid;
        logic       exp_perr;
        logic       exp_ovr;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One bit period: optional idle gap cycles, then a single sample strobe.
    task automatic send_bit(input logic d, input bit gaps, input logic rdy);
        int n;
        if (d) line_in = ~line_in;
        n = gaps ? int'($urandom_range(0, 3)) : 0;
        for (int g = 0; g < n; g++) begin
            sample_en = 1'b0;
            tick();
        end
        sample_en  = 1'b1;
        data_ready = rdy;
        tick();
        sample_en  = 1'b0;
    endtask

    task automatic send_sync(input bit gaps, input logic rdy);
        logic [7:0] s;
        s = 8'h7E;
        for (int i = 7; i >= 0; i--) send_bit(s[i], gaps, rdy);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input bit gaps,
                              input logic rdy_body, input logic rdy_last);
        send_sync(gaps, rdy_body);
        for (int i = 0; i < 8; i++) send_bit(data[i], gaps, rdy_body);
        send_bit(par, gaps, rdy_last);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        line_in     = 1'b0;
        sample_en   = 1'b0;
        data_ready  = 1'b0;
        overrun_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " data_out"},   32'(data_out),   32'h0);
        check({tag, " data_valid"}, 32'(data_valid), 32'h0);
        check({tag, " parity_err"}, 32'(parity_err), 32'h0);
        check({tag, " overrun"},    32'(overrun),    32'h0);
        check({tag, " frame_cnt"},  32'(frame_cnt),  32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //          data   par   rdy   out    vld   perr  ovr   cnt
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'd2};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 8'd3};
        vecs[3] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'd4};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'd5};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'd6};

        do_reset();
        check_all_zero("reset");

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].par, 1'b0, vecs[v].rdy, vecs[v].rdy);
            check($sformatf("vec%0d data_out", v),   32'(data_out),   32'(vecs[v].exp_out));
            check($sformatf("vec%0d data_valid", v), 32'(data_valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d parity_err", v), 32'(parity_err), 32'(vecs[v].exp_perr));
            check($sformatf("vec%0d overrun", v),    32'(overrun),    32'(vecs[v].exp_ovr));
            check($sformatf("vec%0d frame_cnt", v),  32'(frame_cnt),  32'(vecs[v].exp_cnt));
        end

        // Consume with no new frame clears data_valid.
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("consume data_valid", 32'(data_valid), 32'h0);

        // Overrun then clear.
        do_reset();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr data_out",  32'(data_out),  32'hA5);
        check("ovr overrun",   32'(overrun),   32'h1);
        check("ovr frame_cnt", 32'(frame_cnt), 32'd2);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr cleared", 32'(overrun), 32'h0);

        // Set and clear coinciding: set must win.
        overrun_clr = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        overrun_clr = 1'b0;
        check("ovr set wins", 32'(overrun), 32'h1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;

        // Consume and load on the same completion cycle.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        data_ready = 1'b0;
        check("simul data_out",   32'(data_out),   32'h3C);
        check("simul data_valid", 32'(data_valid), 32'h1);
        check("simul overrun",    32'(overrun),    32'h0);
        tick();
        check("hold data_out",   32'(data_out),   32'h3C);
        check("hold data_valid", 32'(data_valid), 32'h1);

        // Gapped sampling.
        do_reset();
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        check("gap data_out",   32'(data_out),   32'hA5);
        check("gap data_valid", 32'(data_valid), 32'h1);
        check("gap parity_err", 32'(parity_err), 32'h0);
        check("gap frame_cnt",  32'(frame_cnt),  32'd1);

        // Reset in the middle of the data field.
        send_sync(1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        rst       = 1'b1;
        line_in   = 1'b0;
        sample_en = 1'b1;
        tick();
        rst       = 1'b0;
        sample_en = 1'b0;
        check_all_zero("midrst");
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        check("postrst data_out",  32'(data_out),  32'hA5);
        check("postrst frame_cnt", 32'(frame_cnt), 32'd1);

        // Frame counter wrap.
        do_reset();
        for (int f = 0; f < 256; f++) begin
            logic [7:0] b;
            b = 8'(f);
            send_frame(b, ^b, 1'b0, 1'b1, 1'b1);
            if (f == 254) check("wrap cnt255", 32'(frame_cnt), 32'd255);
        end
        check("wrap frame_cnt",  32'(frame_cnt),  32'h00);
        check("wrap data_out",   32'(data_out),   32'hFF);
        check("wrap parity_err", 32'(parity_err), 32'h0);
        check("wrap overrun",    32'(overrun),    32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
